// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester's byte at a time to a UART transmitter.
// Latency: gnt one cycle after req is seen in IDLE; tx_int STROBE_CYC cycles; done 3 edges after bps_start falls.
// Backpressure: requesters hold req until gnt; no new grant until done or timeout returns the FSM to IDLE.
module uart_tx_arbiter #(
    parameter int          NREQ        = 4,
    parameter int          STROBE_CYC  = 4,
    parameter logic [23:0] TIMEOUT_CYC = 24'd6000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic                bps_start,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic [2:0]          err_id,
    output logic                busy,
    output logic [7:0]          tx_data,
    output logic                tx_int
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_START, WAIT_DONE} state_t;

    localparam logic [3:0]  STB_LAST = 4'(STROBE_CYC - 1);
    localparam logic [23:0] TMO_LAST = TIMEOUT_CYC - 24'd1;

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q, done_q;
    logic              err_q, busy_q, tx_int_q;
    logic [2:0]        err_id_q, owner_q, last_q;
    logic [7:0]        tx_data_q;
    logic [3:0]        stb_q;
    logic [23:0]       tmo_q;
    logic              bs1_q, bs_s_q;

    logic              win_vld_d;
    logic [2:0]        win_idx_d;
    logic              tmo_hit;

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_id  = err_id_q;
    assign busy    = busy_q;
    assign tx_data = tx_data_q;
    assign tx_int  = tx_int_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    // Scan offsets from farthest to nearest so the requester closest after last_q wins.
    always_comb begin
        int idx;
        win_vld_d = 1'b0;
        win_idx_d = 3'd0;
        idx       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                win_vld_d = 1'b1;
                win_idx_d = 3'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            err_id_q  <= 3'd0;
            busy_q    <= 1'b0;
            tx_int_q  <= 1'b0;
            tx_data_q <= 8'h00;
            owner_q   <= 3'd0;
            last_q    <= 3'(NREQ - 1);
            stb_q     <= 4'd0;
            tmo_q     <= 24'd0;
            bs1_q     <= 1'b0;
            bs_s_q    <= 1'b0;
        end else begin
            bs1_q  <= bps_start;
            bs_s_q <= bs1_q;
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        tx_data_q <= req_data[8*int'(win_idx_d) +: 8];
                        owner_q   <= win_idx_d;
                        last_q    <= win_idx_d;
                        gnt_q     <= NREQ'(1) << win_idx_d;
                        busy_q    <= 1'b1;
                        tx_int_q  <= 1'b1;
                        stb_q     <= 4'd0;
                        state_q   <= STROBE;
                    end
                end
                STROBE: begin
                    if (stb_q == STB_LAST) begin
                        tx_int_q <= 1'b0;
                        tmo_q    <= 24'd0;
                        state_q  <= WAIT_START;
                    end else begin
                        stb_q <= stb_q + 4'd1;
                    end
                end
                WAIT_START: begin
                    if (tmo_hit) begin
                        err_q    <= 1'b1;
                        err_id_q <= owner_q;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 24'd1;
                        if (bs_s_q) state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // bs_s was high on entry, so a low value here is the frame-end edge.
                    if (!bs_s_q) begin
                        done_q  <= NREQ'(1) << owner_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (tmo_hit) begin
                        err_q    <= 1'b1;
                        err_id_q <= owner_q;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 24'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
